// File: rtl/flash_word_packer.sv
// -----------------------------------------------------------------------------
// flash_word_packer
//
// Purpose:
//   Packs the SPI flash reader's byte stream into BYTES_PER_WORD-byte words and
//   buffers them in a first-word-fall-through FIFO. The downstream consumer sees
//   a valid/ready stream. A pacing FSM issues one-cycle read_flash requests every
//   REQ_INTERVAL cycles while the FIFO is below its programmable-full threshold.
//
// Ports:
//   spi_clk    in   sole clock, all logic on the rising edge
//   rst        in   asynchronous active-high reset
//   mydata     in   [7:0] byte from the flash reader
//   myvalid    in   mydata valid this cycle (one byte per cycle)
//   flush      in   pad the partial word with 0x00 lanes and push it
//   read_flash out  one-cycle flash read request
//   out_data   out  [8*BYTES_PER_WORD-1:0] FIFO head word (valid when out_valid)
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer pop; a pop happens when out_valid && out_ready
//   level      out  [AW:0] words stored, 0..DEPTH
//   full       out  level == DEPTH
//   prog_full  out  level >= PROG_FULL_THRESH
//   overflow   out  sticky: a completed word was dropped because the FIFO was full
//   drop_cnt   out  [15:0] saturating count of dropped words
//                   (present only when FLASH_PACKER_DROPCNT_EN is defined)
//
// Configuration macro: FLASH_PACKER_DROPCNT_EN
// -----------------------------------------------------------------------------
module flash_word_packer #(
    parameter int BYTES_PER_WORD   = 4,
    parameter int DEPTH            = 16,
    parameter int AW               = 4,
    parameter int PROG_FULL_THRESH = 12,
    parameter int REQ_INTERVAL     = 1000,
    parameter int MSB_FIRST        = 0
) (
    input  logic                          spi_clk,
    input  logic                          rst,
    input  logic [7:0]                    mydata,
    input  logic                          myvalid,
    input  logic                          flush,
    output logic                          read_flash,
    output logic [8*BYTES_PER_WORD-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [AW:0]                   level,
    output logic                          full,
    output logic                          prog_full,
    output logic                          overflow
`ifdef FLASH_PACKER_DROPCNT_EN
    ,
    output logic [15:0]                   drop_cnt
`endif
);

    localparam int WW = 8 * BYTES_PER_WORD;
    localparam int IW = $clog2(BYTES_PER_WORD);
    localparam int CW = $clog2(REQ_INTERVAL);

    typedef enum logic {
        ST_COUNT,
        ST_WAIT_ROOM
    } pace_state_t;

    // Place byte b into the lane that byte index k maps to for the chosen order.
    function automatic logic [WW-1:0] lane_insert(input logic [WW-1:0] word,
                                                  input logic [IW-1:0] k,
                                                  input logic [7:0]    b);
        logic [WW-1:0] r;
        int            lane;
        r = word;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            lane = (MSB_FIRST != 0) ? (BYTES_PER_WORD - 1 - i) : i;
            if (k == i[IW-1:0]) begin
                r[8*lane +: 8] = b;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Byte packing
    // ------------------------------------------------------------------
    logic [IW-1:0] r_idx;
    logic [WW-1:0] r_stage;

    logic          w_last;
    logic          w_complete;
    logic          w_push;
    logic [WW-1:0] w_word;

    assign w_last     = (r_idx == IW'(BYTES_PER_WORD - 1));
    assign w_complete = myvalid && w_last;
    // A flush with a byte that also completes the word is just a normal push.
    assign w_push     = w_complete || (flush && (r_idx != '0));
    assign w_word     = myvalid ? lane_insert(r_stage, r_idx, mydata) : r_stage;

    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_stage <= '0;
        end else if (w_push) begin
            // Cleared so that lanes left unfilled by a later flush read as 0x00.
            r_idx   <= '0;
            r_stage <= '0;
        end else if (myvalid) begin
            r_idx   <= r_idx + IW'(1);
            r_stage <= w_word;
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [WW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_overflow;

    logic          w_full;
    logic          w_prog_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;

    assign w_full      = (r_level == (AW+1)'(DEPTH));
    assign w_prog_full = (r_level >= (AW+1)'(PROG_FULL_THRESH));
    assign out_valid   = (r_level != '0);
    assign w_pop       = out_valid && out_ready;
    // When full, a same-cycle pop frees the head slot, which is the write slot.
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;

    always_ff @(posedge spi_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_data  = r_mem[r_rptr];
    assign level     = r_level;
    assign full      = w_full;
    assign prog_full = w_prog_full;
    assign overflow  = r_overflow;

`ifdef FLASH_PACKER_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    // ------------------------------------------------------------------
    // Read pacing FSM
    // ------------------------------------------------------------------
    pace_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic          r_read_flash;

    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_COUNT;
            r_cnt        <= '0;
            r_read_flash <= 1'b0;
        end else begin
            r_read_flash <= 1'b0;
            case (r_state)
                ST_COUNT: begin
                    if (r_cnt == CW'(REQ_INTERVAL - 1)) begin
                        if (!w_prog_full) begin
                            r_read_flash <= 1'b1;
                            r_cnt        <= '0;
                        end else begin
                            // Counter holds at terminal value while waiting.
                            r_state <= ST_WAIT_ROOM;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_WAIT_ROOM: begin
                    if (!w_prog_full) begin
                        r_read_flash <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= ST_COUNT;
                    end
                end
                default: begin
                    r_state <= ST_COUNT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign read_flash = r_read_flash;

endmodule

// File: tb/tb_flash_word_packer.sv
// -----------------------------------------------------------------------------
// tb_flash_word_packer
//
// Directed and randomized stimulus for flash_word_packer (BPW=4, DEPTH=16,
// PROG_FULL_THRESH=12, REQ_INTERVAL=1000). Two instances share the stimulus:
// one LSB-first, one MSB-first. Expected behaviour comes from a queue-based
// reference model: a list of received bytes, a queue of stored words, and an
// elapsed-cycle counter for the read request pacing.
// -----------------------------------------------------------------------------
module tb_flash_word_packer;

    localparam int BPW    = 4;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int PFT    = 12;
    localparam int RI     = 1000;

    logic        clk;
    logic        rst;
    logic [7:0]  mydata;
    logic        myvalid;
    logic        flush;
    logic        out_ready;

    logic        rf_l, rf_m;
    logic [31:0] data_l, data_m;
    logic        vld_l, vld_m;
    logic [AW:0] lvl_l, lvl_m;
    logic        full_l, full_m;
    logic        pf_l, pf_m;
    logic        ovf_l, ovf_m;
`ifdef FLASH_PACKER_DROPCNT_EN
    logic [15:0] dc_l, dc_m;
`endif

    flash_word_packer #(
        .BYTES_PER_WORD(BPW), .DEPTH(DEPTH), .AW(AW),
        .PROG_FULL_THRESH(PFT), .REQ_INTERVAL(RI), .MSB_FIRST(0)
    ) dut (
        .spi_clk(clk), .rst(rst), .mydata(mydata), .myvalid(myvalid), .flush(flush),
        .read_flash(rf_l), .out_data(data_l), .out_valid(vld_l), .out_ready(out_ready),
        .level(lvl_l), .full(full_l), .prog_full(pf_l), .overflow(ovf_l)
`ifdef FLASH_PACKER_DROPCNT_EN
        , .drop_cnt(dc_l)
`endif
    );

    flash_word_packer #(
        .BYTES_PER_WORD(BPW), .DEPTH(DEPTH), .AW(AW),
        .PROG_FULL_THRESH(PFT), .REQ_INTERVAL(RI), .MSB_FIRST(1)
    ) dut_m (
        .spi_clk(clk), .rst(rst), .mydata(mydata), .myvalid(myvalid), .flush(flush),
        .read_flash(rf_m), .out_data(data_m), .out_valid(vld_m), .out_ready(out_ready),
        .level(lvl_m), .full(full_m), .prog_full(pf_m), .overflow(ovf_m)
`ifdef FLASH_PACKER_DROPCNT_EN
        , .drop_cnt(dc_m)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  part[$];
    logic [31:0] q_l[$];
    logic [31:0] q_m[$];
    bit          m_ovf;
    int          m_dcnt;
    int          m_elapsed;
    bit          m_rf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        part.delete();
        q_l.delete();
        q_m.delete();
        m_ovf     = 1'b0;
        m_dcnt    = 0;
        m_elapsed = 0;
        m_rf      = 1'b0;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ":out_valid"}, 64'(vld_l), 64'(q_l.size() > 0));
        chk({ctx, ":out_valid_m"}, 64'(vld_m), 64'(q_m.size() > 0));
        chk({ctx, ":level"}, 64'(lvl_l), 64'(q_l.size()));
        chk({ctx, ":full"}, 64'(full_l), 64'(q_l.size() == DEPTH));
        chk({ctx, ":prog_full"}, 64'(pf_l), 64'(q_l.size() >= PFT));
        chk({ctx, ":overflow"}, 64'(ovf_l), 64'(m_ovf));
        chk({ctx, ":read_flash"}, 64'(rf_l), 64'(m_rf));
        if (q_l.size() > 0) chk({ctx, ":out_data"}, 64'(data_l), 64'(q_l[0]));
        if (q_m.size() > 0) chk({ctx, ":out_data_m"}, 64'(data_m), 64'(q_m[0]));
`ifdef FLASH_PACKER_DROPCNT_EN
        chk({ctx, ":drop_cnt"}, 64'(dc_l), 64'(m_dcnt));
`endif
    endtask

    // One clock cycle: drive inputs, advance model, check after the edge.
    task automatic step(input string ctx, input bit v, input logic [7:0] d,
                        input bit f, input bit rdy);
        int          kb;
        bit          pop, pf_before, full_before, push;
        logic [31:0] w_l, w_m;
        myvalid   = v;
        mydata    = d;
        flush     = f;
        out_ready = rdy;

        kb          = part.size();
        pop         = (q_l.size() > 0) && rdy;
        pf_before   = (q_l.size() >= PFT);
        full_before = (q_l.size() == DEPTH);
        if (v) part.push_back(d);
        push = (part.size() == BPW) || (f && kb > 0);
        w_l = '0;
        w_m = '0;
        if (push) begin
            for (int i = 0; i < part.size(); i++) begin
                w_l = w_l | (32'(part[i]) << (8 * i));
                w_m = w_m | (32'(part[i]) << (8 * (BPW - 1 - i)));
            end
            part.delete();
        end

        @(posedge clk);
        #1;

        if (pop) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
        end
        if (push) begin
            if (full_before && !pop) begin
                m_ovf = 1'b1;
                if (m_dcnt < 16'hFFFF) m_dcnt++;
            end else begin
                q_l.push_back(w_l);
                q_m.push_back(w_m);
            end
        end
        // Request due once RI cycles have elapsed and there is room.
        if (m_elapsed >= RI - 1 && !pf_before) begin
            m_rf      = 1'b1;
            m_elapsed = 0;
        end else begin
            m_rf      = 1'b0;
            m_elapsed++;
        end
        check_outputs(ctx);
    endtask

    task automatic send_word(input string ctx, input logic [31:0] bytes_lsb_first,
                             input bit rdy_last);
        logic [31:0] b;
        b = bytes_lsb_first;
        for (int i = 0; i < BPW; i++) begin
            step(ctx, 1'b1, b[8*i +: 8], 1'b0, (i == BPW - 1) ? rdy_last : 1'b0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mydata    = '0;
        myvalid   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic packing, both byte orders
        step("pack", 1'b1, 8'h11, 1'b0, 1'b0);
        step("pack", 1'b1, 8'h22, 1'b0, 1'b0);
        step("pack", 1'b1, 8'h33, 1'b0, 1'b0);
        step("pack", 1'b1, 8'h44, 1'b0, 1'b0);
        chk("pack_literal", 64'(data_l), 64'h44332211);
        chk("pack_literal_m", 64'(data_m), 64'h11223344);
        step("pop", 1'b0, 8'h00, 1'b0, 1'b1);

        // Flush of a partial word, no byte in the flush cycle
        step("flush", 1'b1, 8'hAA, 1'b0, 1'b0);
        step("flush", 1'b1, 8'hBB, 1'b0, 1'b0);
        step("flush", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_literal", 64'(data_l), 64'h0000BBAA);
        step("pop", 1'b0, 8'h00, 1'b0, 1'b1);
        // Flush carrying a byte, flush with nothing staged, flush on completion
        step("flushv", 1'b1, 8'hCC, 1'b0, 1'b0);
        step("flushv", 1'b1, 8'hDD, 1'b1, 1'b0);
        step("flush_idle", 1'b0, 8'h00, 1'b1, 1'b0);
        step("flushc", 1'b1, 8'h01, 1'b0, 1'b0);
        step("flushc", 1'b1, 8'h02, 1'b0, 1'b0);
        step("flushc", 1'b1, 8'h03, 1'b0, 1'b0);
        step("flushc", 1'b1, 8'h04, 1'b1, 1'b0);
        step("flush_k0v", 1'b1, 8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("drain", 1'b0, 8'h00, 1'b0, 1'b1);
        step("flush_k0v", 1'b0, 8'h00, 1'b1, 1'b1);
        step("drain", 1'b0, 8'h00, 1'b0, 1'b1);

        // Pacing with an empty FIFO: at least two periodic requests
        for (int i = 0; i < 2100; i++) step("pace_empty", 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, drop one word, then a completion with a pop
        for (int i = 0; i < DEPTH; i++) send_word("fill", $urandom, 1'b0);
        send_word("drop", 32'hDEADBEEF, 1'b0);
        send_word("full_pop", 32'hCAFEF00D, 1'b1);
        // Hold above threshold across a request time, then release
        for (int i = 0; i < 1100; i++) step("pace_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("pace_release", 1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-word with level 5
        for (int i = 0; i < 5; i++) send_word("pre_rst", $urandom, 1'b0);
        step("pre_rst", 1'b1, 8'h77, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 8'h88, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 1'b1, 8'hA1, 1'b0, 1'b0);
        step("post_rst", 1'b1, 8'hB2, 1'b0, 1'b0);
        step("post_rst", 1'b1, 8'hC3, 1'b0, 1'b0);
        step("post_rst", 1'b1, 8'hD4, 1'b0, 1'b0);
        chk("post_rst_literal", 64'(data_l), 64'hD4C3B2A1);
        step("pop", 1'b0, 8'h00, 1'b0, 1'b1);

        // Random stream with random back-pressure and occasional flushes
        for (int i = 0; i < 700; i++) begin
            step("random",
                 $urandom_range(0, 3) != 0,
                 8'($urandom),
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 20; i++) step("final_drain", 1'b0, 8'h00, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
